// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 constants for the fetch front end and decode controller
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [XLEN-1:0] NOP   = 32'h0000_0013;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry {pc, inst} FIFO whose head entry is the registered output
module fetch_buf
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_inst,
  output logic [1:0]      count,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_inst
);
  logic [XLEN-1:0] tail_pc, tail_inst;
  logic [1:0] keep;
  // occupancy left after this cycle's pop decides where a push lands
  always_comb keep = count - {1'b0, pop && count != 2'd0};
  // head shifts up from tail on pop; push fills the first free slot
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      head_pc <= '0;
      head_inst <= '0;
      tail_pc <= '0;
      tail_inst <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      assert (!(push && keep == 2'd2)) else $error("fetch_buf overflow");
      count <= keep + {1'b0, push};
      if (pop && count == 2'd2) begin
        head_pc <= tail_pc;
        head_inst <= tail_inst;
      end
      if (push && keep == 2'd0) begin
        head_pc <= push_pc;
        head_inst <= push_inst;
      end
      if (push && keep == 2'd1) begin
        tail_pc <= push_pc;
        tail_inst <= push_inst;
      end
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: RV32 fetch front end owning the PC, with buffered output and branch redirect
module inst_fetch
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int IMEM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic [XLEN-1:0]    inst,
  output logic [XLEN-1:0]    inst_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               fault
);
  logic [XLEN-1:0] pc, fl_pc, fetch_pc;
  logic fl, fl_epoch, epoch, pop, push, issue, aligned;
  logic [1:0] count;
  // redirect overrides normal issue and kills the response returning this cycle
  always_comb begin
    pop = inst_valid && inst_ready;
    aligned = redirect_pc[1:0] == 2'b00;
    push = fl && !redirect && fl_epoch == epoch;
    issue = !rst && (redirect ? aligned
          : !fault && ({1'b0, count} + {2'b0, fl} - {2'b0, pop}) <= 3'd1);
    fetch_pc = redirect ? redirect_pc : pc;
  end
  assign imem_en = issue;
  assign imem_addr = fetch_pc[IMEM_AW+1:2];
  assign inst_valid = count != 2'd0;
  // PC, single in-flight read tag, epoch and sticky misalignment fault
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      fl <= 1'b0;
      fl_pc <= '0;
      fl_epoch <= 1'b0;
      epoch <= 1'b0;
      fault <= 1'b0;
    end else begin
      fl <= issue;
      if (issue) begin
        fl_pc <= fetch_pc;
        fl_epoch <= epoch ^ redirect;
        pc <= fetch_pc + 32'd4;
      end
      if (redirect) begin
        epoch <= !epoch;
        fault <= !aligned;
      end
    end
  end
  fetch_buf u_buf (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(redirect),
    .push_pc(fl_pc),
    .push_inst(imem_rdata),
    .count(count),
    .head_pc(inst_pc),
    .head_inst(inst)
  );
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and randomized checks of inst_fetch against a sequential-PC stream model
module tb_inst_fetch;
  localparam int AW = 14;
  logic clk = 1'b0, rst = 1'b1, imem_en, inst_valid, inst_ready = 1'b0, redirect = 1'b0, fault;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_rdata = '0, inst, inst_pc, redirect_pc = '0;
  int checks = 0, errors = 0;
  logic [31:0] exp_pc = '0, hold_pc = '0, hold_inst = '0;
  logic exp_fault = 1'b0, hold = 1'b0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0), .IMEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .fault(fault)
  );

  function automatic logic [31:0] word(input logic [AW-1:0] a);
    return 32'h0000_0013 + ({18'b0, a} << 20);
  endfunction

  always @(posedge clk) if (imem_en) imem_rdata <= word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock: model checks at negedge, then returns 1 time unit after the rising edge
  task automatic cyc();
    @(negedge clk);
    if (rst) begin
      chk("en_in_rst", imem_en, 0);
      exp_pc = 32'h0;
      exp_fault = 1'b0;
      hold = 1'b0;
    end else begin
      chk("fault", fault, exp_fault);
      if (hold) begin
        chk("hold_valid", inst_valid, 1);
        chk("hold_pc", inst_pc, hold_pc);
        chk("hold_inst", inst, hold_inst);
      end
      if (exp_fault && !redirect) begin
        chk("en_faulted", imem_en, 0);
        chk("valid_faulted", inst_valid, 0);
      end
      if (inst_valid && inst_ready) begin
        chk("pc", inst_pc, exp_pc);
        chk("inst", inst, word(exp_pc[AW+1:2]));
        exp_pc += 32'd4;
      end
      hold = inst_valid && !inst_ready && !redirect;
      hold_pc = inst_pc;
      hold_inst = inst;
      if (redirect) begin
        exp_fault = redirect_pc[1:0] != 2'b00;
        if (exp_fault) chk("misalign_en", imem_en, 0);
        else begin
          chk("redir_en", imem_en, 1);
          chk("redir_addr", imem_addr, redirect_pc[AW+1:2]);
          exp_pc = redirect_pc;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset, then free-running stream
    rst = 1'b1; inst_ready = 1'b1;
    cyc(); cyc();
    #1;
    chk("rst_valid", inst_valid, 0); chk("rst_inst", inst, 0); chk("rst_pc", inst_pc, 0);
    chk("rst_fault", fault, 0); chk("rst_en", imem_en, 0);
    rst = 1'b0;
    #1;
    chk("c0_en", imem_en, 1); chk("c0_addr", imem_addr, 0); chk("c0_valid", inst_valid, 0);
    cyc();
    #1 chk("c1_valid", inst_valid, 0);
    cyc();
    #1 chk("c2_valid", inst_valid, 1); chk("c2_pc", inst_pc, 0);
    repeat (8) begin #1 chk("stream_valid", inst_valid, 1); cyc(); end
    // fill buffer, then pulse reset
    inst_ready = 1'b0;
    cyc(); cyc();
    #1 chk("full_en", imem_en, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rr_valid", inst_valid, 0); chk("rr_inst", inst, 0); chk("rr_pc", inst_pc, 0);
    chk("rr_fault", fault, 0); chk("rr_en", imem_en, 1); chk("rr_addr", imem_addr, 0);
    cyc();
    cyc();
    #1 chk("rr_c2_valid", inst_valid, 1); chk("rr_c2_pc", inst_pc, 0);
    repeat (5) begin #1 chk("stall_en", imem_en, 0); cyc(); end
    inst_ready = 1'b1;
    #1 chk("resume_en", imem_en, 1);
    repeat (4) begin #1 chk("resume_valid", inst_valid, 1); cyc(); end
    // redirect with a read in flight and a transfer in the same cycle
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    #1 chk("rd_xfer_valid", inst_valid, 1);
    cyc();
    redirect = 1'b0;
    #1 chk("rd_n1_valid", inst_valid, 0);
    cyc();
    #1 chk("rd_n2_valid", inst_valid, 1); chk("rd_n2_pc", inst_pc, 32'h100);
    repeat (3) cyc();
    // misaligned redirect, then recovery
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    cyc();
    redirect = 1'b0;
    #1 chk("mis_fault", fault, 1);
    repeat (4) cyc();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    cyc();
    redirect = 1'b0;
    #1 chk("clr_fault", fault, 0);
    cyc();
    #1 chk("clr_valid", inst_valid, 1); chk("clr_pc", inst_pc, 32'h200);
    repeat (3) cyc();
    // PC wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cyc();
    redirect = 1'b0;
    repeat (6) cyc();
    #1 chk("wrap_pc", inst_pc, exp_pc);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 60) == 0;
      inst_ready = $urandom_range(0, 3) != 0;
      redirect = $urandom_range(0, 9) == 0;
      redirect_pc = ($urandom & 32'h0000_FFFC)
                  | (($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      cyc();
    end
    rst = 1'b0; redirect = 1'b0; inst_ready = 1'b1;
    repeat (4) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
